// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I load/store constants, LSU state encoding and request helpers
//
// Purpose: funct3 and opcode constants, LSU FSM state type, and small pure
// functions used to classify a request and build its byte enables / write data.
// Ports: none (package).

package riscv_pkg;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUS  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_t;

  // Unknown funct3 or a halfword/word access that straddles its natural boundary.
  function automatic logic lsu_illegal(input logic store, input logic [2:0] f3,
                                       input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (store) begin
      if (f3 > F3_SW) bad = 1'b1;
    end else if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) begin
      bad = 1'b1;
    end
    // LH/LHU/SH share funct3[1:0]=01; LW/SW are funct3=2 (6 is already rejected).
    if (f3[1:0] == 2'b01 && off[0]) bad = 1'b1;
    if (f3 == F3_LW && off != 2'b00) bad = 1'b1;
    return bad;
  endfunction

  function automatic logic [3:0] lsu_be(input logic store, input logic [2:0] f3,
                                        input logic [1:0] off);
    logic [3:0] be;
    be = 4'b1111;
    if (store) begin
      case (f3)
        F3_SB:   be = 4'b0001 << off;
        F3_SH:   be = off[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
    return be;
  endfunction

  // Replicate the store operand across all lanes so the byte enables alone pick the target.
  function automatic logic [31:0] lsu_wdata(input logic [2:0] f3, input logic [31:0] data);
    logic [31:0] w;
    case (f3)
      F3_SB:   w = {4{data[7:0]}};
      F3_SH:   w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - extracts and extends a load result from a 32-bit bus word
//
// Purpose: combinational lane select plus sign/zero extension for RV32I loads.
// Ports:
//   rdata  in  32  word returned by memory
//   offset in  2   byte offset of the original address
//   funct3 in  3   load funct3 (LB/LH/LW/LBU/LHU)
//   result out 32  extended load value

import riscv_pkg::*;

module lsu_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  result = {24'd0, byte_sel};
      F3_LHU:  result = {16'd0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-side load/store unit driving a word-addressed memory bus
//
// Purpose: accepts one load/store per handshake, rejects illegal/misaligned
// requests, performs one bus transfer with optional timeout, returns the result.
// Ports:
//   clk, rst (async active-low)
//   req_valid/req_ready/req_store/req_funct3/req_addr/req_wdata  request side
//   resp_valid/resp_rdata/resp_err                               response side
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata/mem_ack/mem_rdata    memory bus

import riscv_pkg::*;

module load_store_unit #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic             resp_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_ack,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Counter value at the edge on which the TIMEOUT-th unacknowledged cycle ends.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  lsu_state_t state, state_next;

  logic          op_store;
  logic [2:0]    op_f3;
  logic [1:0]    op_off;
  logic [CW-1:0] cnt;
  logic          req_bad;
  logic          timeout_hit;
  logic [31:0]   load_result;

  assign req_bad = lsu_illegal(req_store, req_funct3, req_addr[1:0]);

  lsu_load_align u_align (
    .rdata  (mem_rdata),
    .offset (op_off),
    .funct3 (op_f3),
    .result (load_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LSU_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    req_ready   = (state == LSU_IDLE);
    mem_req     = (state == LSU_BUS);
    resp_valid  = (state == LSU_RESP);
    case (state)
      LSU_IDLE: if (req_valid) state_next = req_bad ? LSU_RESP : LSU_BUS;
      LSU_BUS: begin
        if (mem_ack) begin
          state_next = LSU_RESP;
        end else if (TIMEOUT > 0 && cnt == TO_LAST) begin
          timeout_hit = 1'b1;
          state_next  = LSU_RESP;
        end
      end
      LSU_RESP: state_next = LSU_IDLE;
      default:  state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_store   <= 1'b0;
      op_f3      <= 3'd0;
      op_off     <= 2'd0;
      cnt        <= '0;
      mem_we     <= 1'b0;
      mem_be     <= 4'd0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            cnt      <= '0;
            op_store <= req_store;
            op_f3    <= req_funct3;
            op_off   <= req_addr[1:0];
            if (req_bad) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_we    <= req_store;
              mem_be    <= lsu_be(req_store, req_funct3, req_addr[1:0]);
              mem_addr  <= {req_addr[WIDTH-1:2], 2'b00};
              mem_wdata <= req_store ? lsu_wdata(req_funct3, req_wdata) : '0;
            end
          end
        end
        LSU_BUS: begin
          if (mem_ack) begin
            resp_err   <= 1'b0;
            resp_rdata <= op_store ? '0 : load_result;
          end else begin
            cnt <= cnt + 1'b1;
            if (timeout_hit) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.WIDTH(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered and left at posedge+1 with the unit idle.
  task automatic do_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    req_valid = 1'b1; req_store = v.store; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (v.err) begin
      chk({t, "_mem_req"}, {31'd0, mem_req}, 32'd0);
      chk({t, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({t, "_resp_err"}, {31'd0, resp_err}, 32'd1);
      chk({t, "_resp_rdata"}, resp_rdata, 32'd0);
    end else begin
      chk({t, "_mem_req"}, {31'd0, mem_req}, 32'd1);
      chk({t, "_mem_we"}, {31'd0, mem_we}, {31'd0, v.store});
      chk({t, "_mem_be"}, {28'd0, mem_be}, {28'd0, v.be});
      chk({t, "_mem_addr"}, mem_addr, v.maddr);
      if (v.store) chk({t, "_mem_wdata"}, mem_wdata, v.mwdata);
      chk({t, "_early_resp"}, {31'd0, resp_valid}, 32'd0);
      mem_ack = 1'b1; mem_rdata = v.rdata;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk({t, "_mem_req_drop"}, {31'd0, mem_req}, 32'd0);
      chk({t, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({t, "_resp_err"}, {31'd0, resp_err}, 32'd0);
      chk({t, "_resp_rdata"}, resp_rdata, v.res);
    end
    @(posedge clk); #1;
    chk({t, "_resp_pulse"}, {31'd0, resp_valid}, 32'd0);
    chk({t, "_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int n;
    int k;
    //            store f3     addr          wdata         rdata         err   be     maddr         mwdata        res
    vecs[0]  = '{1'b0, 3'd2, 32'h00000100, 32'h0,        32'hDEADBEEF, 1'b0, 4'hF, 32'h00000100, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'd0, 32'h00000103, 32'h0,        32'h80FF7F01, 1'b0, 4'hF, 32'h00000100, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b0, 3'd4, 32'h00000103, 32'h0,        32'h80FF7F01, 1'b0, 4'hF, 32'h00000100, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b0, 3'd1, 32'h00000102, 32'h0,        32'h80FF7F01, 1'b0, 4'hF, 32'h00000100, 32'h0,        32'hFFFF80FF};
    vecs[4]  = '{1'b0, 3'd5, 32'h00000100, 32'h0,        32'h80FF7F01, 1'b0, 4'hF, 32'h00000100, 32'h0,        32'h00007F01};
    vecs[5]  = '{1'b0, 3'd0, 32'h00000101, 32'h0,        32'h80FF7F01, 1'b0, 4'hF, 32'h00000100, 32'h0,        32'h0000007F};
    vecs[6]  = '{1'b1, 3'd1, 32'h00000206, 32'h1234ABCD, 32'h55555555, 1'b0, 4'hC, 32'h00000204, 32'hABCDABCD, 32'h0};
    vecs[7]  = '{1'b1, 3'd0, 32'h00000301, 32'h000000A5, 32'h55555555, 1'b0, 4'h2, 32'h00000300, 32'hA5A5A5A5, 32'h0};
    vecs[8]  = '{1'b1, 3'd2, 32'h00000400, 32'hCAFEF00D, 32'h55555555, 1'b0, 4'hF, 32'h00000400, 32'hCAFEF00D, 32'h0};
    vecs[9]  = '{1'b0, 3'd2, 32'h00000101, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0,        32'h0};
    vecs[10] = '{1'b1, 3'd3, 32'h00000100, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0,        32'h0};
    vecs[11] = '{1'b0, 3'd1, 32'h00000103, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0,        32'h0};
    vecs[12] = '{1'b0, 3'd6, 32'h00000100, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0,        32'h0};
    vecs[13] = '{1'b1, 3'd2, 32'h00000402, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0,        32'h0};

    // Reset state
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) do_vec(vecs[i], i);

    // Timeout: no ack, mem_req must stay up exactly 4 cycles
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h500;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0; k = 0;
    while (mem_req && k < 20) begin
      n++; k++;
      @(posedge clk); #1;
    end
    chk("to_req_cycles", n, 32'd4);
    chk("to_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("to_resp_err", {31'd0, resp_err}, 32'd1);
    chk("to_resp_rdata", resp_rdata, 32'd0);
    @(posedge clk); #1;
    // Stray ack while idle
    mem_ack = 1'b1; mem_rdata = 32'h11111111;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("stray_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("stray_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    chk("stray_resp_valid2", {31'd0, resp_valid}, 32'd0);

    // Ack arriving on the timeout edge wins
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h600;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    chk("race_mem_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("race_resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("race_resp_err", {31'd0, resp_err}, 32'd0);
    chk("race_resp_rdata", resp_rdata, 32'h12345678);
    @(posedge clk); #1;

    // Reset in the middle of a bus access
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h700;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid_mem_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk); rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h99999999;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    chk("late_ack_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("late_ack_mem_req", {31'd0, mem_req}, 32'd0);
    chk("late_ack_req_ready", {31'd0, req_ready}, 32'd1);
    do_vec(vecs[0], 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
